// File: rtl/vec_ctrl_pkg.sv
// Shared types and default sizing for the vector issue controller.
//
// Contents:
//   issue_state_e   : issue FSM state encoding (IDLE, ISSUE, EXEC, RESP)
//   INST_W_DEFAULT  : default width of one vector instruction word
//   DEPTH_DEFAULT   : default instruction queue depth (power of 2, >= 2)
package vec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } issue_state_e;

    localparam int INST_W_DEFAULT = 32;
    localparam int DEPTH_DEFAULT  = 4;

endpackage

// File: rtl/vec_inst_fifo.sv
// In-order instruction queue: synchronous FIFO with flush.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (empty queue, pointers 0)
//   push   : write din this cycle (ignored when full)
//   din    : word to write
//   pop    : discard head this cycle (ignored when empty)
//   flush  : empty the queue this cycle; wins over push and pop
//   dout   : current head word (valid when !empty)
//   count  : number of stored entries
//   full   : count == DEPTH
//   empty  : count == 0
module vec_inst_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Issue controller between the scalar processor and the vector datapath.
// Buffers instructions in an in-order queue, launches one at a time with a
// start pulse, waits for completion and hands an acknowledge back to the
// scalar side, holding it until the scalar side is ready.
//
// Ports:
//   clk              : clock, rising edge
//   reset            : asynchronous active-low reset
//   inst_valid       : scalar -> ctrl, inst_in is valid
//   inst_in          : scalar -> ctrl, instruction word
//   vec_pro_ready    : ctrl -> scalar, queue can accept (from registered count)
//   flush            : discard all queued, not-yet-issued instructions
//   dp_inst          : ctrl -> datapath, instruction in flight (registered)
//   dp_start         : ctrl -> datapath, one-cycle launch pulse
//   inst_done        : datapath -> ctrl, in-flight instruction finished
//   vec_pro_ack      : ctrl -> scalar, completion valid
//   scalar_pro_ready : scalar -> ctrl, completion accepted
//   inst_count       : queued, not-yet-issued entries
//   busy             : FSM not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing in flight; leave when the queue holds an entry
// ISSUE | dp_start high for this one cycle; dp_inst already loaded
// EXEC  | waiting for inst_done; ack mirrors inst_done combinationally
// RESP  | done seen, scalar not ready yet; ack held high
module vec_issue_ctrl
    import vec_ctrl_pkg::*;
#(
    parameter  int INST_W = INST_W_DEFAULT,
    parameter  int DEPTH  = DEPTH_DEFAULT,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst_in,
    output logic              vec_pro_ready,
    input  logic              flush,
    output logic [INST_W-1:0] dp_inst,
    output logic              dp_start,
    input  logic              inst_done,
    output logic              vec_pro_ack,
    input  logic              scalar_pro_ready,
    output logic [CNT_W-1:0]  inst_count,
    output logic              busy
);

    issue_state_e      state;
    issue_state_e      next_state;
    logic              push_acc;
    logic              issue_go;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [INST_W-1:0] fifo_head;
    logic [CNT_W-1:0]  count_after;

    assign vec_pro_ready = ~fifo_full;
    assign push_acc      = inst_valid & vec_pro_ready;
    assign busy          = (state != IDLE);

    // Occupancy once this cycle's push and flush have taken effect; used to
    // decide whether a completion chains straight into the next issue.
    assign count_after = flush ? '0 : inst_count + CNT_W'(push_acc);

    // The head is popped and latched into dp_inst on the edge that enters
    // ISSUE, so dp_inst is already valid while dp_start is high. When a
    // completion chains on an empty queue, the only candidate is the word
    // being pushed right now; take it directly instead of through the FIFO.
    assign issue_go  = (next_state == ISSUE);
    assign bypass    = issue_go & fifo_empty;
    assign fifo_push = push_acc & ~bypass;
    assign fifo_pop  = issue_go & ~bypass;

    vec_inst_fifo #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (inst_in),
        .pop   (fifo_pop),
        .flush (flush),
        .dout  (fifo_head),
        .count (inst_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dp_inst <= '0;
        end else begin
            state <= next_state;
            if (issue_go) dp_inst <= bypass ? inst_in : fifo_head;
        end
    end

    always_comb begin
        next_state  = state;
        dp_start    = 1'b0;
        vec_pro_ack = 1'b0;
        case (state)
            IDLE: begin
                if (inst_count != '0 && !flush) next_state = ISSUE;
            end
            ISSUE: begin
                dp_start   = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                vec_pro_ack = inst_done;
                if (inst_done) begin
                    if (scalar_pro_ready)
                        next_state = (count_after != '0) ? ISSUE : IDLE;
                    else
                        next_state = RESP;
                end
            end
            RESP: begin
                vec_pro_ack = 1'b1;
                if (scalar_pro_ready)
                    next_state = (count_after != '0) ? ISSUE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
